step_ctrl: RTL

STEP_CTRL -- requirements
Module: step_ctrl

---
 rtl/step_ctrl_pkg.sv | 16 +
 rtl/step_ctrl_debouncer.sv | 38 +++
 rtl/step_ctrl.sv | 59 +++++
 3 files changed

// File: rtl/step_ctrl_pkg.sv
// step_ctrl_pkg: stage-index constants, defaults and counter-width helpers for step_ctrl.
package step_ctrl_pkg;
  localparam logic [2:0] STG_FETCH  = 3'd0;
  localparam logic [2:0] STG_DECODE = 3'd1;
  localparam logic [2:0] STG_REGRD  = 3'd2;
  localparam logic [2:0] STG_EXEC   = 3'd3;
  localparam logic [2:0] STG_MEM    = 3'd4;
  localparam logic [2:0] STG_WB     = 3'd5;
  localparam int NUM_STAGES_DEF = 6;
  function automatic int deb_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
  function automatic int div_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/step_ctrl_debouncer.sv
// debouncer: two-flop synchronizer, stability filter and one-cycle press event for an active-low button.
module debouncer
  import step_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  output logic press
);
  localparam int CW = deb_w(DEB_CYCLES);
  logic [1:0] sync_q, sync_d;
  logic stable_q, stable_d, press_q, press_d, differ, done;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    sync_d   = {sync_q[0], raw_n};
    differ   = ~sync_q[1] != stable_q;
    done     = differ && cnt_q == CW'(DEB_CYCLES - 1);
    cnt_d    = (differ && !done) ? cnt_q + 1'b1 : '0;
    stable_d = done ? ~stable_q : stable_q;
    press_d  = done && !stable_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end
  assign press = press_q;
endmodule

// File: rtl/step_ctrl.sv
// step_ctrl: turns debounced buttons and the run switch into a single-cycle core step enable
// and a wrapping visualization stage index.
module step_ctrl
  import step_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int RUN_DIV    = 25000000,
  parameter int NUM_STAGES = NUM_STAGES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_step_n,
  input  logic       btn_sel_n,
  input  logic       sw_run,
  output logic       step_pulse,
  output logic [2:0] sel,
  output logic       run_active
);
  localparam int DW = div_w(RUN_DIV);
  logic step_ev, sel_ev, chg, tick;
  logic [1:0] run_sync_q, run_sync_d;
  logic run_q, run_d, step_pulse_q, step_pulse_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0] sel_q, sel_d;
  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
    .clk(clk), .reset(reset), .raw_n(btn_step_n), .press(step_ev)
  );
  debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
    .clk(clk), .reset(reset), .raw_n(btn_sel_n), .press(sel_ev)
  );
  // A mode change restarts the divider and swallows a tick landing on the same edge.
  always_comb begin
    run_sync_d   = {run_sync_q[0], sw_run};
    run_d        = run_sync_q[1];
    chg          = run_d != run_q;
    tick         = run_q && !chg && div_q == DW'(RUN_DIV - 1);
    div_d        = (chg || !run_q || tick) ? '0 : div_q + 1'b1;
    step_pulse_d = run_q ? tick : step_ev;
    sel_d        = !sel_ev ? sel_q : (sel_q == 3'(NUM_STAGES - 1)) ? STG_FETCH : sel_q + 3'd1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_sync_q   <= 2'b00;
      run_q        <= 1'b0;
      div_q        <= '0;
      step_pulse_q <= 1'b0;
      sel_q        <= STG_FETCH;
    end else begin
      run_sync_q   <= run_sync_d;
      run_q        <= run_d;
      div_q        <= div_d;
      step_pulse_q <= step_pulse_d;
      sel_q        <= sel_d;
    end
  end
  assign step_pulse = step_pulse_q;
  assign sel        = sel_q;
  assign run_active = run_q;
endmodule
